// File: rtl/pattern_det_pkg.sv
// ============================================================================
// Module      : pattern_det_pkg
// Description : Shared definitions for the programmable pattern detector:
//               one-hot run-controller state encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pattern_det_pkg;

  // Default geometry of the detector.
  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int FRAME_W_DEF = 8;

  // One-hot run-controller states.
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_RUN  = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pattern_match_core.sv
// ============================================================================
// Module      : pattern_match_core
// Description : History shift register, fill counter and length-masked
//               compare. The match output is combinational and reflects the
//               history after the current bit has been shifted in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en_i,
  input  logic               clear_i,
  input  logic               d_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic               overlap_i,
  output logic               match_o
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   fill_inc;

  // Post-shift view of the history, masked compare and next-state update.
  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], d_i};
    fill_inc   = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_q + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_i);
    end
    match_o = shift_en_i && (len_i != '0) && (fill_inc >= len_i) &&
              ((hist_shift & mask) == (pattern_i & mask));
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en_i) begin
      hist_d = hist_shift;
      // Non-overlapping mode restarts the fill so no bit is reused.
      fill_d = (match_o && !overlap_i) ? '0 : fill_inc;
    end
  end

  // History and fill registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pattern_det_ctrl.sv
// ============================================================================
// Module      : pattern_det_ctrl
// Description : Programmable serial pattern detector run controller. Accepts
//               a pattern configuration over valid/ready, runs a bounded or
//               unbounded detection frame, counts matches and flags the end
//               of frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_det_ctrl
  import pattern_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [FRAME_W-1:0] cfg_frame_bits,
  input  logic               start,
  input  logic               stop,
  input  logic               d_valid,
  input  logic               d_in,
  output logic               busy,
  output logic               pattern_detect,
  output logic [CNT_W-1:0]   det_count,
  output logic               overflow,
  output logic               done
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [FRAME_W-1:0] frame_bits_q, frame_bits_d;
  logic               loaded_q, loaded_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               det_q, det_d;

  logic               cfg_hs;
  logic               cfg_ok;
  logic [LEN_W-1:0]   len_clamped;
  logic               core_clear;
  logic               shift_en;
  logic               match;

  pattern_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .clear_i    (core_clear),
    .d_i        (d_in),
    .len_i      (len_q),
    .pattern_i  (pat_q),
    .overlap_i  (ovl_q),
    .match_o    (match)
  );

  // Config is only offered in IDLE and never while reset is asserted.
  assign cfg_ready      = (state_q == S_IDLE) && rst;
  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign pattern_detect = det_q;
  assign det_count      = cnt_q;
  assign overflow       = ovf_q;

  // Next-state, config capture, frame/match counting.
  always_comb begin
    cfg_hs       = cfg_valid && cfg_ready;
    cfg_ok       = cfg_hs && (cfg_len != '0);
    len_clamped  = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    state_d      = state_q;
    pat_d        = pat_q;
    len_d        = len_q;
    ovl_d        = ovl_q;
    frame_bits_d = frame_bits_q;
    loaded_d     = loaded_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    frame_cnt_d  = frame_cnt_q;
    det_d        = 1'b0;
    core_clear   = 1'b0;
    shift_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_ok) begin
          pat_d        = cfg_pattern;
          len_d        = len_clamped;
          ovl_d        = cfg_overlap;
          frame_bits_d = cfg_frame_bits;
          loaded_d     = 1'b1;
        end
        // A config accepted in the same cycle qualifies the start.
        if (start && (loaded_q || cfg_ok)) begin
          state_d     = S_RUN;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          frame_cnt_d = '0;
          core_clear  = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (d_valid) begin
          shift_en    = 1'b1;
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (match) begin
            det_d = 1'b1;
            if (cnt_q == '1) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if ((frame_bits_q != '0) && (frame_cnt_d == frame_bits_q)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, configuration and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pat_q        <= '0;
      len_q        <= '0;
      ovl_q        <= 1'b0;
      frame_bits_q <= '0;
      loaded_q     <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      frame_cnt_q  <= '0;
      det_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      ovl_q        <= ovl_d;
      frame_bits_q <= frame_bits_d;
      loaded_q     <= loaded_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      frame_cnt_q  <= frame_cnt_d;
      det_q        <= det_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pattern_det_ctrl.sv
// ============================================================================
// Module      : tb_pattern_det_ctrl
// Description : Self-checking bench for pattern_det_ctrl. Table records of
//               stimulus and expected outputs feed a scoreboard queue that is
//               drained one clock later; hand-written sequences cover reset,
//               config rejection and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pattern_det_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_frame_bits;
  logic       start, stop, d_valid, d_in;

  logic       cfg_ready, busy, pattern_detect, overflow, done;
  logic [7:0] det_count;
  logic       s_cfg_ready, s_busy, s_detect, s_overflow, s_done;
  logic [1:0] s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pattern_det_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .FRAME_W(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_frame_bits(cfg_frame_bits), .start(start), .stop(stop),
    .d_valid(d_valid), .d_in(d_in), .busy(busy),
    .pattern_detect(pattern_detect), .det_count(det_count),
    .overflow(overflow), .done(done)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation.
  pattern_det_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2), .FRAME_W(8)) u_dut_sat (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_frame_bits(cfg_frame_bits), .start(start), .stop(stop),
    .d_valid(d_valid), .d_in(d_in), .busy(s_busy),
    .pattern_detect(s_detect), .det_count(s_count),
    .overflow(s_overflow), .done(s_done)
  );

  typedef struct {
    logic       dv, d, stp, cv;
    logic       exp_rdy, exp_det, exp_done, exp_busy;
    logic [7:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic       det, done, busy;
    logic [7:0] cnt;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic dv, d, stp, cv, rdy, det, dn, bsy, input logic [7:0] cnt);
    vec_t v;
    v.dv = dv; v.d = d; v.stp = stp; v.cv = cv;
    v.exp_rdy = rdy; v.exp_det = det; v.exp_done = dn; v.exp_busy = bsy; v.exp_cnt = cnt;
    tv.push_back(v);
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic [7:0] frame, input logic with_start);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; cfg_frame_bits = frame; start = with_start;
    #1;
    check("cfg_ready_idle", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive table records [lo,hi]; expectations go through the scoreboard.
  task automatic run_range(input int lo, input int hi);
    exp_t e, g;
    for (int i = lo; i <= hi; i++) begin
      d_valid = tv[i].dv; d_in = tv[i].d; stop = tv[i].stp; cfg_valid = tv[i].cv;
      if (tv[i].cv) begin
        cfg_pattern = 8'h00; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_frame_bits = 8'd3;
      end
      #1;
      check("cfg_ready_vec", cfg_ready, tv[i].exp_rdy);
      e.det = tv[i].exp_det; e.done = tv[i].exp_done;
      e.busy = tv[i].exp_busy; e.cnt = tv[i].exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        g = sb.pop_front();
        check("pattern_detect", pattern_detect, g.det);
        check("done", done, g.done);
        check("busy", busy, g.busy);
        check("det_count", det_count, g.cnt);
      end
    end
    d_valid = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    logic [6:0]  s1;
    logic [20:0] s3;
    logic [7:0]  c;
    int b1, b2, b3, b4;

    // ---------------- table construction ----------------
    s1 = 7'b1011011;
    // T1: non-overlap 1011, junk cfg offered for first 3 bits, then stop.
    c = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) c++;
      add(1, s1[6-i], 0, (i < 3), 0, (i == 3), 0, 1, c);
    end
    add(1, 1, 1, 0, 0, 0, 0, 0, 8'd1);
    b1 = tv.size() - 1;
    // T2: overlap 1011, matches after bits 4 and 7.
    c = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3 || i == 6) c++;
      add(1, s1[6-i], 0, 0, 0, (i == 3 || i == 6), 0, 1, c);
    end
    add(1, 1, 1, 0, 0, 0, 0, 0, 8'd2);
    b2 = tv.size() - 1;
    // T3: 21-bit frame, overlap, matches end at bits 4, 8, 14, 21.
    s3 = 21'b101110110010110001011;
    c = 0;
    for (int i = 0; i < 21; i++) begin
      logic hit;
      hit = (i == 3 || i == 7 || i == 13 || i == 20);
      if (hit) c++;
      add(1, s3[20-i], 0, 0, 0, hit, (i == 20), (i != 20), c);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'd4);
    b3 = tv.size() - 1;
    // T4: gapped 1011 in a 4-bit frame, invalid cycles carry misleading data.
    add(0, 0, 0, 0, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 0, 0, 0, 0, 1, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 8'd0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 8'd0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 0, 0, 0, 0, 1, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 0, 0, 1, 1, 0, 8'd1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'd1);
    b4 = tv.size() - 1;

    // ---------------- reset ----------------
    rst = 1'b0; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
    cfg_frame_bits = 0; start = 0; stop = 0; d_valid = 0; d_in = 0;
    tick(); tick();
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_detect", pattern_detect, 0);
    check("rst_count", det_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    #1;
    check("idle_cfg_ready", cfg_ready, 1);

    // start with no config is ignored
    do_start();
    check("start_unloaded", busy, 0);
    // zero-length config is rejected
    do_cfg(8'h0B, 4'd0, 1'b0, 8'd0, 1'b0);
    do_start();
    check("len0_rejected", busy, 0);

    // T1
    do_cfg(8'h0B, 4'd4, 1'b0, 8'd0, 1'b0);
    do_start();
    check("t1_busy", busy, 1);
    check("t1_count_clr", det_count, 0);
    run_range(0, b1);
    // T2
    do_cfg(8'h0B, 4'd4, 1'b1, 8'd0, 1'b0);
    do_start();
    run_range(b1 + 1, b2);
    // T3: config and start in the same cycle
    do_cfg(8'h0B, 4'd4, 1'b1, 8'd21, 1'b1);
    check("t3_busy", busy, 1);
    run_range(b2 + 1, b3);
    // T4: valid config, then rejected len=0 offer must not disturb it
    do_cfg(8'h0B, 4'd4, 1'b0, 8'd4, 1'b0);
    do_cfg(8'h00, 4'd0, 1'b1, 8'd0, 1'b0);
    do_start();
    run_range(b3 + 1, b4);

    // Saturation on the 2-bit counter instance
    do_cfg(8'h01, 4'd1, 1'b0, 8'd0, 1'b0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      d_valid = 1'b1; d_in = 1'b1;
      tick();
      check("sat_count", s_count, (i >= 2) ? 3 : i + 1);
      check("sat_overflow", s_overflow, (i >= 3));
      check("sat_detect", s_detect, 1);
      check("wide_count", det_count, i + 1);
    end
    d_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sat_hold_ovf", s_overflow, 1);
    do_start();
    check("restart_busy", s_busy, 1);
    check("restart_count", s_count, 0);
    check("restart_ovf", s_overflow, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Reset in the middle of a run
    do_start();
    d_valid = 1'b1; d_in = 1'b1;
    tick(); tick();
    check("pre_rst_count", det_count, 2);
    d_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("mid_rst_cfg_ready", cfg_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_detect", pattern_detect, 0);
    check("mid_rst_count", det_count, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b1;
    do_start();
    check("rst_clears_loaded", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pattern_det_ctrl.md
Name: pattern_det_ctrl

Overview:
- Run controller for the team's serial pattern detectors.
- Accepts a runtime pattern configuration (bits, length, overlap mode, frame length) over a valid/ready handshake.
- Sequences a bounded detection run over a qualified serial bit stream, counts matches and signals end of frame.
- Sits between the register/config side and the serial input; replaces per-pattern hard-coded FSMs with one programmable block.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits.
- LEN_W, 4: width of the length field; must hold MAX_LEN.
- CNT_W, 8: width of the detection counter.
- FRAME_W, 8: width of the frame bit counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset. **Synchronous, active-low.**
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accepted this cycle when high with cfg_valid.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length, 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_frame_bits  in  FRAME_W  bits per run; 0 = unbounded (ends only on stop).
- start  in  1  begin a run.
- stop  in  1  abort a run.
- d_valid  in  1  d_in qualifier.
- d_in  in  1  serial data bit.
- busy  out  1  high in RUN.
- pattern_detect  out  1  one-cycle match pulse.
- det_count  out  CNT_W  matches in the current/last run.
- overflow  out  1  sticky; det_count saturated.
- done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset (rst low at a clock edge):
  - state=IDLE; all outputs 0; cfg_ready=0 during reset.
  - Config cleared; cfg_loaded=0; history, fill count and frame count cleared.
  - Applies mid-run with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_ready=1. A handshake latches pattern, overlap and frame_bits, and sets cfg_loaded=1.
  - cfg_len=0 is rejected: handshake completes but cfg_loaded and the stored config are unchanged.
  - cfg_len>MAX_LEN is clamped to MAX_LEN.
  - start with cfg_loaded=1 goes to RUN next cycle, clearing det_count, overflow, history, fill count and frame count. start with cfg_loaded=0 is ignored.
  - Config handshake and start in the same cycle: the new config is latched and used by the run.
- RUN:
  - cfg_ready=0; busy=1.
  - Each cycle with d_valid=1: shift d_in into history (newest at [0]), fill=min(fill+1,MAX_LEN), frame count +1.
  - Match when fill>=len and history[len-1:0]==pattern[len-1:0], evaluated on the post-shift history.
  - Match response:
    - pattern_detect=1 in the cycle after the matching bit's edge (registered, Moore-style).
    - det_count+1, saturating at all-ones; an increment attempted at saturation sets overflow.
    - Non-overlap mode: fill resets to 0, so no bit is shared between matches.
  - A d_in sampled in the start cycle is not consumed.
  - Accepting bit number frame_bits (frame_bits≠0) goes to DONE. A match on that last bit still pulses pattern_detect, coincident with done.
  - stop=1 goes to IDLE next cycle: the current bit is discarded and no done pulse is produced. If stop arrives with the last frame bit, stop wins.
  - d_valid=0 cycles hold all state.
- DONE:
  - Lasts one cycle: done=1, busy=0, then IDLE.
  - det_count and overflow hold until the next start.
  - Config is retained; back-to-back runs need only start.
- Widths:
  - The frame counter compares for equality with frame_bits.
  - The fill counter is LEN_W bits.
  - Pattern bits above len are don't-care.

Decomposition:
- Shared package pattern_det_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE, one-hot 3-bit, matching existing FSM style.
  - default MAX_LEN/CNT_W/FRAME_W constants.
- One sub-module, pattern_match_core:
  - contains history shift register, fill counter and masked compare.
  - inputs: shift enable, clear, len, pattern, overlap.
  - output: match.
  - The controller holds the FSM, config registers and counters.

Test Plan:
- Config 1011, len 4, non-overlap, frame 0; stream 1,0,1,1,0,1,1 → exactly 1 pattern_detect, one cycle after the 4th bit; det_count=1; stop returns to IDLE with no done.
- Same stream with overlap=1 → 2 pulses (after bits 4 and 7); det_count=2.
- Frame 21, overlap, 1011; stream 1,0,1,1,1,0,1,1,0,0,1,0,1,1,0,0,0,1,0,1,1 → det_count=4; done pulses once after bit 21, coincident with the 4th pattern_detect; busy falls.
- CNT_W=2, pattern 1 len 1, 5 ones → det_count saturates at 3; overflow=1; cleared by the next start.
- Robustness:
  - cfg_valid during RUN → cfg_ready=0 and config unchanged.
  - start before any config → stays IDLE.
  - rst low mid-run → all outputs 0 next cycle, cfg_loaded=0.
- d_valid gaps (alternating 0/1 during 1011) → same single detect as the gapless case; frame count advances only on valid bits.
